ysyx_22041412_cache_axi_responder: RTL and testbench

//  Memory-side responder for the Dcache's split AXI-style read/write request ports.

---
 rtl/ysyx_22041412_resp_pkg.sv | 35 +++
 rtl/ysyx_22041412_resp_chan.sv | 101 ++++++++++
 rtl/ysyx_22041412_cache_axi_responder.sv | 158 +++++++++++++++
 tb/tb_ysyx_22041412_cache_axi_responder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041412_resp_pkg.sv
// Shared definitions for the Dcache-side memory responder.
//   - chan_state_e : per-channel FSM encoding (IDLE / WAIT / BEAT)
//   - SZ_*         : write access size codes, in bits
//   - size_mask()  : byte-lane mask for an access of a given size at a byte offset
//   - RESP_BASE_ADDR : default first mapped byte address
package ysyx_22041412_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_BEAT = 2'd2
  } chan_state_e;

  localparam logic [7:0] SZ_8  = 8'd8;
  localparam logic [7:0] SZ_16 = 8'd16;
  localparam logic [7:0] SZ_32 = 8'd32;
  localparam logic [7:0] SZ_64 = 8'd64;

  localparam logic [31:0] RESP_BASE_ADDR = 32'h8000_0000;

  // Unknown size codes fall back to a full 64-bit access. Lanes shifted past
  // byte 7 are discarded, so a misaligned access never spills into the next word.
  function automatic logic [7:0] size_mask(input logic [7:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      SZ_8:    m = 8'h01;
      SZ_16:   m = 8'h03;
      SZ_32:   m = 8'h0F;
      SZ_64:   m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/ysyx_22041412_resp_chan.sv
// One request channel of the responder: IDLE -> WAIT -> BEAT -> IDLE.
// Used once for reads and once for writes; the parent owns addresses and data.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   valid     : request valid, held for the whole burst
//   len       : beats-1, sampled on acceptance
//   accept    : request taken this cycle (IDLE and valid)
//   state     : current FSM state, exported for observation
//   beat      : index of the beat currently presented
//   last      : current beat is the final one (only in BEAT)
//   done      : final beat completes this cycle (BEAT, valid, last)
// Parameters:
//   LAT                : cycles from acceptance to the first beat, >= 1
//   HOLD_ON_IDLE_VALID : 1 = valid low in BEAT stalls the beat, 0 = it aborts
//
// Handshake: a beat completes on a cycle where state is BEAT and valid is high;
// valid low in WAIT always aborts back to IDLE without completing the burst.
module ysyx_22041412_resp_chan
  import ysyx_22041412_resp_pkg::*;
#(
  parameter int LAT                = 1,
  parameter bit HOLD_ON_IDLE_VALID = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  len,
  output logic        accept,
  output chan_state_e state,
  output logic [7:0]  beat,
  output logic        last,
  output logic        done
);

  chan_state_e state_q, state_d;
  logic [7:0]  lat_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            len_q  <= len;
            lat_q  <= 8'(LAT - 1);
            beat_q <= '0;
          end
        end
        ST_WAIT: begin
          if (lat_q != 8'd0) lat_q <= lat_q - 8'd1;
        end
        ST_BEAT: begin
          if (valid) beat_q <= beat_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!valid)              state_d = ST_IDLE;
        else if (lat_q == 8'd0)  state_d = ST_BEAT;
      end
      ST_BEAT: begin
        last = (beat_q == len_q);
        if (valid) begin
          if (last) begin
            done    = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (!HOLD_ON_IDLE_VALID) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;
  assign beat  = beat_q;

endmodule

// File: rtl/ysyx_22041412_cache_axi_responder.sv
// Memory-side responder for the Dcache's split read/write request ports.
// Serves bursts from an internal word-addressed array; read and write channels
// run independently.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   r_valid_i/addr/len       : read request, held until the last beat
//   r_ready_o/r_data_o/last  : read beat presented this cycle, its data, final flag
//   w_valid_i/addr/len/size/strb/data : write request and beat data
//   w_ready_o/w_last_o       : write beat accepted this cycle, final flag
//   rd_bursts_o/wr_bursts_o  : completed burst counters (wrap at 2^64)
//   err_o                    : sticky error flag, only with RESP_ERR_FLAG_EN
// Optional feature macro: RESP_ERR_FLAG_EN adds err_o, set by any out-of-range
// beat or a request with len > 1, cleared only by rst.
//
// Handshake: a request is held valid from acceptance until its last beat; a
// beat completes when ready and valid are both high. Read beats never stall,
// write beats wait while w_valid_i is low. Out-of-range beats complete
// normally, reading zero and discarding write data.
module ysyx_22041412_cache_axi_responder
  import ysyx_22041412_resp_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter int          MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = RESP_BASE_ADDR,
  parameter int          RD_LAT    = 2,
  parameter int          WR_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_valid_i,
  input  logic [31:0]       r_addr_i,
  input  logic [7:0]        r_len_i,
  output logic              r_ready_o,
  output logic [DATA_W-1:0] r_data_o,
  output logic              r_last_o,
  input  logic              w_valid_i,
  input  logic [31:0]       w_addr_i,
  input  logic [7:0]        w_len_i,
  input  logic [7:0]        w_size_i,
  input  logic [7:0]        w_strb_i,
  input  logic [DATA_W-1:0] w_data_i,
  output logic              w_ready_o,
  output logic              w_last_o,
  output logic [63:0]       rd_bursts_o,
  output logic [63:0]       wr_bursts_o
`ifdef RESP_ERR_FLAG_EN
  ,
  output logic              err_o
`endif
);

  localparam int          IW   = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) << 3;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'(((a - BASE_ADDR) >> 3) % 32'(MEM_WORDS));
  endfunction

  // Read channel
  logic        r_accept, r_last, r_done;
  chan_state_e r_state;
  logic [7:0]  r_beat;
  logic [31:0] r_addr_q, r_beat_addr;
  logic        r_in_range;

  ysyx_22041412_resp_chan #(.LAT(RD_LAT), .HOLD_ON_IDLE_VALID(1'b0)) u_rd (
    .clk(clk), .rst(rst), .valid(r_valid_i), .len(r_len_i),
    .accept(r_accept), .state(r_state), .beat(r_beat), .last(r_last), .done(r_done)
  );

  // Write channel
  logic        w_accept, w_last, w_done;
  chan_state_e w_state;
  logic [7:0]  w_beat;
  logic [31:0] w_addr_q, w_beat_addr;
  logic [2:0]  w_off_q;
  logic        w_in_range, w_commit;
  logic [7:0]  w_mask;
  logic [DATA_W-1:0] w_wdata;

  ysyx_22041412_resp_chan #(.LAT(WR_LAT), .HOLD_ON_IDLE_VALID(1'b1)) u_wr (
    .clk(clk), .rst(rst), .valid(w_valid_i), .len(w_len_i),
    .accept(w_accept), .state(w_state), .beat(w_beat), .last(w_last), .done(w_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr_q    <= '0;
      w_addr_q    <= '0;
      w_off_q     <= '0;
      rd_bursts_o <= '0;
      wr_bursts_o <= '0;
    end else begin
      if (r_accept) r_addr_q <= r_addr_i & ~32'h7;
      if (w_accept) begin
        w_addr_q <= w_addr_i & ~32'h7;
        w_off_q  <= w_addr_i[2:0];
      end
      if (r_done) rd_bursts_o <= rd_bursts_o + 64'd1;
      if (w_done) wr_bursts_o <= wr_bursts_o + 64'd1;
    end
  end

  assign r_beat_addr = r_addr_q + {21'd0, r_beat, 3'd0};
  assign r_in_range  = in_range(r_beat_addr);
  assign r_ready_o   = (r_state == ST_BEAT);
  assign r_last_o    = r_last;
  // Combinational array read: a write landing on the same edge is not yet visible.
  assign r_data_o    = (r_ready_o && r_in_range) ? mem[word_idx(r_beat_addr)] : '0;

  assign w_beat_addr = w_addr_q + {21'd0, w_beat, 3'd0};
  assign w_in_range  = in_range(w_beat_addr);
  assign w_ready_o   = (w_state == ST_BEAT);
  assign w_last_o    = w_last;
  assign w_commit    = w_ready_o && w_valid_i && w_in_range;

  // The first beat may be a sub-word store: its data arrives low-aligned from
  // the Dcache and is moved up to the addressed byte lane. Later beats are full words.
  always_comb begin
    if (w_beat == 8'd0) begin
      w_mask  = w_strb_i & size_mask(w_size_i, w_off_q);
      w_wdata = w_data_i << {w_off_q, 3'd0};
    end else begin
      w_mask  = 8'hFF;
      w_wdata = w_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 8; b++) begin
        if (w_mask[b]) mem[word_idx(w_beat_addr)][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

`ifdef RESP_ERR_FLAG_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((r_accept && (r_len_i > 8'd1)) || (w_accept && (w_len_i > 8'd1)) ||
                 (r_ready_o && !r_in_range) || (w_ready_o && w_valid_i && !w_in_range)) begin
      err_q <= 1'b1;
    end
  end
  assign err_o = err_q;
`else
  // No error flag in this build: out-of-range beats are absorbed silently.
`endif

endmodule

// File: tb/tb_ysyx_22041412_cache_axi_responder.sv
module tb_ysyx_22041412_cache_axi_responder;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r_valid_i, r_ready_o, r_last_o;
  logic [31:0] r_addr_i;
  logic [7:0]  r_len_i;
  logic [63:0] r_data_o;
  logic        w_valid_i, w_ready_o, w_last_o;
  logic [31:0] w_addr_i;
  logic [7:0]  w_len_i, w_size_i, w_strb_i;
  logic [63:0] w_data_i;
  logic [63:0] rd_bursts_o, wr_bursts_o;
`ifdef RESP_ERR_FLAG_EN
  logic        err_o;
`endif

  ysyx_22041412_cache_axi_responder dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_len_i(r_len_i),
    .r_ready_o(r_ready_o), .r_data_o(r_data_o), .r_last_o(r_last_o),
    .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .w_len_i(w_len_i),
    .w_size_i(w_size_i), .w_strb_i(w_strb_i), .w_data_i(w_data_i),
    .w_ready_o(w_ready_o), .w_last_o(w_last_o),
    .rd_bursts_o(rd_bursts_o), .wr_bursts_o(wr_bursts_o)
`ifdef RESP_ERR_FLAG_EN
    , .err_o(err_o)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [63:0] exp_rd = 64'd0;
  logic [63:0] exp_wr = 64'd0;
  logic [63:0] exp_q[$];

  localparam logic [63:0] DA = 64'hA5A5_0001_DEAD_BEEF;
  localparam logic [63:0] DB = 64'h5A5A_0002_CAFE_F00D;

  // Driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len,
                          output logic [63:0] d0, output logic [63:0] d1,
                          output logic [1:0] lasts, output int first_cyc,
                          output int last_cyc, output int nbeats);
    int k;
    bit fin;
    k = 0; fin = 0; first_cyc = -1; last_cyc = -1;
    d0 = '0; d1 = '0; lasts = '0;
    r_addr_i = addr; r_len_i = len; r_valid_i = 1'b1;
    for (int c = 1; c <= 40 && !fin; c++) begin
      step();
      if (r_ready_o) begin
        if (k == 0) begin first_cyc = c; d0 = r_data_o; end
        else if (k == 1) d1 = r_data_o;
        if (k < 2) lasts[k] = r_last_o;
        last_cyc = c;
        k++;
        if (r_last_o) fin = 1;
      end
    end
    nbeats = k;
    if (fin) step();
    r_valid_i = 1'b0;
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len,
                          input logic [7:0] size, input logic [7:0] strb,
                          input logic [63:0] d0, input logic [63:0] d1,
                          output logic [1:0] lasts, output int first_cyc,
                          output int nbeats);
    int k;
    bit fin;
    k = 0; fin = 0; first_cyc = -1; lasts = '0;
    w_addr_i = addr; w_len_i = len; w_size_i = size; w_strb_i = strb;
    w_data_i = d0; w_valid_i = 1'b1;
    for (int c = 1; c <= 40 && !fin; c++) begin
      step();
      if (w_ready_o) begin
        if (k == 0) first_cyc = c;
        w_data_i = (k == 0) ? d0 : d1;
        if (k < 2) lasts[k] = w_last_o;
        k++;
        if (w_last_o) fin = 1;
      end
    end
    nbeats = k;
    if (fin) step();
    w_valid_i = 1'b0;
  endtask

  // Shared observation variables
  logic [63:0] rd0, rd1, got;
  logic [1:0]  rl, wl;
  int rfc, rlc, rnb, wfc, wnb;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    tests_run++; if (r_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_r_ready: got %0b want 0", r_ready_o); end
    tests_run++; if (w_ready_o !== 1'b0) begin tests_failed++; $display("FAIL reset_w_ready: got %0b want 0", w_ready_o); end
    tests_run++; if (r_last_o !== 1'b0 || w_last_o !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got r%0b w%0b want 0", r_last_o, w_last_o); end
    tests_run++; if (r_data_o !== 64'd0) begin tests_failed++; $display("FAIL reset_r_data: got %h want 0", r_data_o); end
    tests_run++; if (rd_bursts_o !== 64'd0 || wr_bursts_o !== 64'd0) begin tests_failed++; $display("FAIL reset_counters: got %0d/%0d want 0/0", rd_bursts_o, wr_bursts_o); end
`ifdef RESP_ERR_FLAG_EN
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %0b want 0", err_o); end
`endif
  endtask

  task automatic test_line_write();
    wr_burst(32'h8000_0010, 8'd1, 8'd64, 8'hFF, DA, DB, wl, wfc, wnb);
    exp_wr++;
    tests_run++; if (wfc !== 2) begin tests_failed++; $display("FAIL wr_latency: got %0d want 2", wfc); end
    tests_run++; if (wnb !== 2 || wl !== 2'b10) begin tests_failed++; $display("FAIL wr_line_beats: got n=%0d last=%b want n=2 last=10", wnb, wl); end
    tests_run++; if (wr_bursts_o !== exp_wr) begin tests_failed++; $display("FAIL wr_line_count: got %0d want %0d", wr_bursts_o, exp_wr); end
  endtask

  task automatic test_line_read();
    exp_q.push_back(DA);
    exp_q.push_back(DB);
    rd_burst(32'h8000_0010, 8'd1, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rfc !== 3 || rlc !== 4) begin tests_failed++; $display("FAIL rd_timing: got first=%0d last=%0d want 3/4", rfc, rlc); end
    tests_run++; if (rnb !== 2 || rl !== 2'b10) begin tests_failed++; $display("FAIL rd_line_beats: got n=%0d last=%b want n=2 last=10", rnb, rl); end
    got = exp_q.pop_front();
    tests_run++; if (rd0 !== got) begin tests_failed++; $display("FAIL rd_beat0: got %h want %h", rd0, got); end
    got = exp_q.pop_front();
    tests_run++; if (rd1 !== got) begin tests_failed++; $display("FAIL rd_beat1: got %h want %h", rd1, got); end
    tests_run++; if (rd_bursts_o !== exp_rd) begin tests_failed++; $display("FAIL rd_line_count: got %0d want %0d", rd_bursts_o, exp_rd); end
`ifdef RESP_ERR_FLAG_EN
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL err_in_range: got %0b want 0", err_o); end
`endif
  endtask

  task automatic test_sub_word_write();
    wr_burst(32'h8000_0000, 8'd0, 8'd64, 8'hFF, 64'hAAAA_BBBB_CCCC_DDDD, 64'd0, wl, wfc, wnb);
    exp_wr++;
    wr_burst(32'h8000_0004, 8'd0, 8'd32, 8'hFF, 64'h1122_3344_5566_7788, 64'd0, wl, wfc, wnb);
    exp_wr++;
    tests_run++; if (wnb !== 1 || wl[0] !== 1'b1) begin tests_failed++; $display("FAIL wr32_last: got n=%0d last=%b want n=1 last=1", wnb, wl[0]); end
    rd_burst(32'h8000_0000, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h5566_7788_CCCC_DDDD) begin tests_failed++; $display("FAIL wr32_merge: got %h want 55667788ccccdddd", rd0); end
    wr_burst(32'h8000_0001, 8'd0, 8'd8, 8'hFF, 64'h0000_0000_0000_00EE, 64'd0, wl, wfc, wnb);
    exp_wr++;
    rd_burst(32'h8000_0000, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h5566_7788_CCCC_EEDD) begin tests_failed++; $display("FAIL wr8_merge: got %h want 55667788cccceedd", rd0); end
    // 16-bit store at byte 2 with only strobe bit 2 set: just byte 2 changes.
    wr_burst(32'h8000_0002, 8'd0, 8'd16, 8'h04, 64'h0000_0000_0000_5577, 64'd0, wl, wfc, wnb);
    exp_wr++;
    rd_burst(32'h8000_0000, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h5566_7788_CC77_EEDD) begin tests_failed++; $display("FAIL wr16_strb: got %h want 55667788cc77eedd", rd0); end
    tests_run++; if (wr_bursts_o !== exp_wr) begin tests_failed++; $display("FAIL sub_word_count: got %0d want %0d", wr_bursts_o, exp_wr); end
  endtask

  task automatic test_write_stall();
    bit seen;
    seen = 0;
    w_addr_i = 32'h8000_0020; w_len_i = 8'd1; w_size_i = 8'd64; w_strb_i = 8'hFF;
    w_data_i = 64'h0C0C_0C0C_0C0C_0C0C; w_valid_i = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (w_ready_o) seen = 1;
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL stall_first_beat: got no w_ready_o want ready within 20 cycles"); end
    step();
    w_valid_i = 1'b0;
    w_data_i = 64'hBAAD_BAAD_BAAD_BAAD;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++; if (w_ready_o !== 1'b1 || w_last_o !== 1'b1) begin tests_failed++; $display("FAIL stall_hold_%0d: got ready=%0b last=%0b want 1/1", i, w_ready_o, w_last_o); end
    end
    tests_run++; if (wr_bursts_o !== exp_wr) begin tests_failed++; $display("FAIL stall_count_held: got %0d want %0d", wr_bursts_o, exp_wr); end
    w_valid_i = 1'b1;
    w_data_i = 64'h0D0D_0D0D_0D0D_0D0D;
    step();
    w_valid_i = 1'b0;
    exp_wr++;
    tests_run++; if (wr_bursts_o !== exp_wr || w_ready_o !== 1'b0) begin tests_failed++; $display("FAIL stall_complete: got count=%0d ready=%0b want %0d/0", wr_bursts_o, w_ready_o, exp_wr); end
    rd_burst(32'h8000_0020, 8'd1, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h0C0C_0C0C_0C0C_0C0C || rd1 !== 64'h0D0D_0D0D_0D0D_0D0D) begin tests_failed++; $display("FAIL stall_data: got %h %h want 0c.. 0d..", rd0, rd1); end
  endtask

  task automatic test_out_of_range();
    wr_burst(32'h8000_7FF8, 8'd0, 8'd64, 8'hFF, 64'h1357_9BDF_2468_ACE0, 64'd0, wl, wfc, wnb);
    exp_wr++;
    rd_burst(32'h7FFF_FFF8, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rnb !== 1 || rl[0] !== 1'b1 || rd0 !== 64'd0) begin tests_failed++; $display("FAIL oor_low_read: got n=%0d last=%b data=%h want 1/1/0", rnb, rl[0], rd0); end
    tests_run++; if (rd_bursts_o !== exp_rd) begin tests_failed++; $display("FAIL oor_rd_count: got %0d want %0d", rd_bursts_o, exp_rd); end
`ifdef RESP_ERR_FLAG_EN
    tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL oor_err: got %0b want 1", err_o); end
`endif
    rd_burst(32'h8000_8000, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rnb !== 1 || rd0 !== 64'd0) begin tests_failed++; $display("FAIL oor_high_read: got n=%0d data=%h want 1/0", rnb, rd0); end
    // This address would alias word 4095 if the range check were missing.
    wr_burst(32'h7FFF_FFF8, 8'd0, 8'd64, 8'hFF, 64'hFFFF_0000_FFFF_0000, 64'd0, wl, wfc, wnb);
    exp_wr++;
    tests_run++; if (wnb !== 1 || wr_bursts_o !== exp_wr) begin tests_failed++; $display("FAIL oor_write_hs: got n=%0d count=%0d want 1/%0d", wnb, wr_bursts_o, exp_wr); end
    rd_burst(32'h8000_7FF8, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h1357_9BDF_2468_ACE0) begin tests_failed++; $display("FAIL oor_write_dropped: got %h want 13579bdf2468ace0", rd0); end
  endtask

  task automatic test_read_abort();
    bit seen;
    seen = 0;
    r_addr_i = 32'h8000_0010; r_len_i = 8'd0; r_valid_i = 1'b1;
    step();
    r_valid_i = 1'b0;
    repeat (6) begin
      step();
      if (r_ready_o) seen = 1;
    end
    tests_run++; if (seen || rd_bursts_o !== exp_rd) begin tests_failed++; $display("FAIL rd_abort: got beat=%0b count=%0d want 0/%0d", seen, rd_bursts_o, exp_rd); end
  endtask

  task automatic test_concurrent();
    logic [63:0] c0, c1;
    logic [1:0]  cl, cwl;
    int cfc, clc, cnb, cwfc, cwnb;
    wr_burst(32'h8000_0030, 8'd0, 8'd64, 8'hFF, 64'h0101_0101_0101_0101, 64'd0, wl, wfc, wnb);
    exp_wr++;
    fork
      rd_burst(32'h8000_0030, 8'd0, c0, c1, cl, cfc, clc, cnb);
      begin
        step();
        wr_burst(32'h8000_0030, 8'd0, 8'd64, 8'hFF, 64'h0202_0202_0202_0202, 64'd0, cwl, cwfc, cwnb);
      end
    join
    exp_rd++;
    exp_wr++;
    tests_run++; if (cfc !== 3 || cwfc !== 2) begin tests_failed++; $display("FAIL conc_align: got rd=%0d wr=%0d want 3/2", cfc, cwfc); end
    tests_run++; if (c0 !== 64'h0101_0101_0101_0101) begin tests_failed++; $display("FAIL conc_old_data: got %h want 0101..", c0); end
    rd_burst(32'h8000_0030, 8'd0, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    tests_run++; if (rd0 !== 64'h0202_0202_0202_0202) begin tests_failed++; $display("FAIL conc_new_data: got %h want 0202..", rd0); end
    tests_run++; if (rd_bursts_o !== exp_rd || wr_bursts_o !== exp_wr) begin tests_failed++; $display("FAIL conc_counts: got %0d/%0d want %0d/%0d", rd_bursts_o, wr_bursts_o, exp_rd, exp_wr); end
  endtask

  task automatic test_reset_mid_burst();
    bit seen;
    seen = 0;
    r_addr_i = 32'h8000_0010; r_len_i = 8'd1; r_valid_i = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (r_ready_o) seen = 1;
    end
    rst = 1'b1;
    r_valid_i = 1'b0;
    step();
    exp_rd = 64'd0;
    exp_wr = 64'd0;
    tests_run++; if (!seen || r_ready_o !== 1'b0 || r_last_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_ready: got seen=%0b ready=%0b last=%0b want 1/0/0", seen, r_ready_o, r_last_o); end
    tests_run++; if (rd_bursts_o !== 64'd0 || wr_bursts_o !== 64'd0) begin tests_failed++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", rd_bursts_o, wr_bursts_o); end
    rst = 1'b0;
    repeat (2) step();
    tests_run++; if (r_ready_o !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_idle: got ready=%0b want 0", r_ready_o); end
    exp_q.push_back(DA);
    exp_q.push_back(DB);
    rd_burst(32'h8000_0010, 8'd1, rd0, rd1, rl, rfc, rlc, rnb);
    exp_rd++;
    got = exp_q.pop_front();
    tests_run++; if (rd0 !== got) begin tests_failed++; $display("FAIL rst_after_beat0: got %h want %h", rd0, got); end
    got = exp_q.pop_front();
    tests_run++; if (rd1 !== got || rfc !== 3) begin tests_failed++; $display("FAIL rst_after_beat1: got %h first=%0d want %h first=3", rd1, rfc, got); end
    tests_run++; if (rd_bursts_o !== exp_rd) begin tests_failed++; $display("FAIL rst_after_count: got %0d want %0d", rd_bursts_o, exp_rd); end
  endtask

  initial begin
    rst = 1'b1;
    r_valid_i = 1'b0; r_addr_i = '0; r_len_i = '0;
    w_valid_i = 1'b0; w_addr_i = '0; w_len_i = '0;
    w_size_i = 8'd64; w_strb_i = 8'hFF; w_data_i = '0;
    test_reset();
    test_line_write();
    test_line_read();
    test_sub_word_write();
    test_write_stall();
    test_out_of_range();
    test_read_abort();
    test_concurrent();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
